// File: rtl/hpc_dump_tx.sv
// Purpose: freezes the live performance counters into a shadow bank, serves word reads and streams it as a packet.
// Latency: snapshot on the request edge; read data one cycle after the address; first packet word one cycle after dump_req_i.
// Backpressure: packet words are held stable while tx_ready_i is low; requests arriving during a dump are dropped.
// Optional: define HPC_DUMP_CSUM_EN to append an XOR checksum word to the bank and packet.
module hpc_dump_tx #(
   parameter int NUM_CNT = 8,
   parameter int AW      = 8
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic [NUM_CNT*32-1:0] cnt_flat_i,
   input  logic [63:0]          cyc_i,
   input  logic                 snap_req_i,
   input  logic                 dump_req_i,
   input  logic [AW-1:0]        rd_addr_i,
   output logic [31:0]          rd_data_o,
   output logic                 snap_valid_o,
   output logic                 busy_o,
   output logic                 tx_valid_o,
   output logic [31:0]          tx_data_o,
   output logic                 tx_last_o,
   input  logic                 tx_ready_i,
   output logic                 dump_done_o
);

`ifdef HPC_DUMP_CSUM_EN
   localparam int N_WORDS = NUM_CNT + 4;
`else
   localparam int N_WORDS = NUM_CNT + 3;
`endif
   localparam logic [31:0] HDR = {16'hC0DE, 8'h00, 8'(N_WORDS)};

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [31:0] cnt_q [NUM_CNT];
   logic [63:0] cyc_q;
   logic        snap_valid_q;
   logic [31:0] rd_data_q, rd_data_d;
   logic [31:0] tx_data_q, tx_data_d;
   logic        tx_last_q, tx_last_d;
   logic        capture;
   logic [31:0] words [N_WORDS];
   logic [31:0] tx_word;

   // Only an idle block may overwrite the shadow bank, so a frame in flight never changes.
   assign capture = (state_q == S_IDLE) && (snap_req_i || dump_req_i);

`ifdef HPC_DUMP_CSUM_EN
   logic [31:0] csum;
   // Checksum covers header, all counters and both cycle halves.
   always_comb begin
      csum = HDR ^ cyc_q[31:0] ^ cyc_q[63:32];
      for (int k = 0; k < NUM_CNT; k++) csum = csum ^ cnt_q[k];
   end
`endif

   // Word map of the shadow bank as seen by both the read port and the packet.
   always_comb begin
      words[0] = HDR;
      for (int k = 0; k < NUM_CNT; k++) words[k+1] = cnt_q[k];
      words[NUM_CNT+1] = cyc_q[31:0];
      words[NUM_CNT+2] = cyc_q[63:32];
`ifdef HPC_DUMP_CSUM_EN
      words[NUM_CNT+3] = csum;
`endif
   end

   // Random-access read mux; addresses past the map return zero.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < N_WORDS; i++)
         if (int'(rd_addr_i) == i) rd_data_d = words[i];
   end

   // Dump FSM next state, word index and the registered packet word/last flag.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tx_data_d = tx_data_q;
      tx_last_d = tx_last_q;
      tx_word   = '0;
      case (state_q)
         S_IDLE: if (dump_req_i) begin
            state_d = S_SEND;
            idx_d   = '0;
         end
         S_SEND: if (tx_ready_i) begin
            if (int'(idx_q) == N_WORDS - 1) state_d = S_DONE;
            else idx_d = idx_q + 8'd1;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      for (int i = 0; i < N_WORDS; i++)
         if (int'(idx_d) == i) tx_word = words[i];
      // Header does not depend on the bank, so the word loaded on the capture edge is already correct.
      if ((state_q == S_IDLE && state_d == S_SEND) ||
          (state_q == S_SEND && state_d == S_SEND && idx_d != idx_q)) begin
         tx_data_d = tx_word;
         tx_last_d = (int'(idx_d) == N_WORDS - 1);
      end else if (state_d == S_DONE) begin
         tx_last_d = 1'b0;
      end
   end

   // State, shadow bank and output registers; reset abandons any packet immediately.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cyc_q        <= '0;
         snap_valid_q <= 1'b0;
         rd_data_q    <= '0;
         tx_data_q    <= '0;
         tx_last_q    <= 1'b0;
         for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_data_q <= rd_data_d;
         tx_data_q <= tx_data_d;
         tx_last_q <= tx_last_d;
         if (capture) begin
            for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= cnt_flat_i[32*k +: 32];
            cyc_q        <= cyc_i;
            snap_valid_q <= 1'b1;
         end
      end
   end

   assign rd_data_o    = rd_data_q;
   assign snap_valid_o = snap_valid_q;
   assign busy_o       = (state_q != S_IDLE);
   assign tx_valid_o   = (state_q == S_SEND);
   assign tx_data_o    = tx_data_q;
   assign tx_last_o    = tx_last_q;
   assign dump_done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_hpc_dump_tx.sv
// Bench for hpc_dump_tx: random counter values against a word-map model, scoreboarded packet and read checks.
module tb_hpc_dump_tx;
   localparam int NC = 8;
   localparam int AW = 8;
`ifdef HPC_DUMP_CSUM_EN
   localparam int NW = NC + 4;
`else
   localparam int NW = NC + 3;
`endif

   logic          clk, rst_i;
   logic [NC*32-1:0] cnt_flat_i;
   logic [63:0]   cyc_i;
   logic          snap_req_i, dump_req_i, tx_ready_i;
   logic [AW-1:0] rd_addr_i;
   logic [31:0]   rd_data_o, tx_data_o;
   logic          snap_valid_o, busy_o, tx_valid_o, tx_last_o, dump_done_o;

   hpc_dump_tx #(.NUM_CNT(NC), .AW(AW)) dut (
      .clk(clk), .rst_i(rst_i), .cnt_flat_i(cnt_flat_i), .cyc_i(cyc_i),
      .snap_req_i(snap_req_i), .dump_req_i(dump_req_i), .rd_addr_i(rd_addr_i),
      .rd_data_o(rd_data_o), .snap_valid_o(snap_valid_o), .busy_o(busy_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o),
      .tx_ready_i(tx_ready_i), .dump_done_o(dump_done_o));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: what the shadow bank should hold.
   logic [31:0] m_cnt [NC];
   logic [63:0] m_cyc;
   logic        m_valid;
   logic [31:0] live_cnt [NC];
   logic [63:0] live_cyc;

   function automatic logic [31:0] m_base(input int i);
      if (i == 0) return {16'hC0DE, 8'h00, 8'(NW)};
      if (i >= 1 && i <= NC) return m_cnt[i-1];
      if (i == NC + 1) return m_cyc[31:0];
      if (i == NC + 2) return m_cyc[63:32];
      return 32'h0;
   endfunction

   function automatic logic [31:0] m_word(input int i);
      logic [31:0] x;
`ifdef HPC_DUMP_CSUM_EN
      if (i == NC + 3) begin
         x = 32'h0;
         for (int j = 0; j < NC + 3; j++) x = x ^ m_base(j);
         return x;
      end
`endif
      x = m_base(i);
      return x;
   endfunction

   typedef struct packed { logic [31:0] d; logic l; } exp_t;
   exp_t        exp_q [$];
   logic [31:0] rd_q [$];
   bit          mon_en = 0;
   bit          rd_en = 0;
   bit          done_next = 0;
   bit          exp_done;
   int          hs_cnt = 0;
   int          rd_avail;

   task automatic apply_live();
      for (int k = 0; k < NC; k++) cnt_flat_i[32*k +: 32] = live_cnt[k];
      cyc_i = live_cyc;
   endtask

   task automatic rand_live(input bit ones);
      for (int k = 0; k < NC; k++) live_cnt[k] = (ones && k[0]) ? 32'hFFFF_FFFF : $urandom;
      live_cyc = {$urandom, $urandom};
   endtask

   task automatic take_snap();
      for (int k = 0; k < NC; k++) m_cnt[k] = live_cnt[k];
      m_cyc   = live_cyc;
      m_valid = 1'b1;
   endtask

   task automatic push_packet();
      for (int i = 0; i < NW; i++) exp_q.push_back('{d: m_word(i), l: (i == NW - 1)});
      hs_cnt = 0;
   endtask

   // One clock step; issues a read (random address when addr<0) whose answer is due next cycle.
   task automatic cycle(input int addr);
      int a;
      @(posedge clk);
      #1;
      if (rd_en) begin
         a = (addr < 0) ? int'($urandom_range(0, 255)) : addr;
         rd_addr_i = a[AW-1:0];
         rd_q.push_back(m_word(a));
      end
   endtask

   // Read monitor: a read issued before this edge is due by the following falling edge.
   always begin
      @(posedge clk);
      rd_avail = rd_q.size();
      @(negedge clk);
      if (rd_avail > 0 && rd_q.size() > 0) chk("rd_data", rd_data_o, rd_q.pop_front());
   end

   // Packet monitor: every presented word must match the head of the expected queue.
   always @(negedge clk) begin
      if (mon_en && !rst_i) begin
         exp_done  = done_next;
         done_next = 0;
         if (exp_done || dump_done_o) chk("dump_done", 32'(dump_done_o), 32'(exp_done));
         if (tx_valid_o) begin
            if (exp_q.size() == 0) chk("tx_extra", 32'(tx_valid_o), 32'h0);
            else begin
               chk("tx_data", tx_data_o, exp_q[0].d);
               chk("tx_last", 32'(tx_last_o), 32'(exp_q[0].l));
               if (tx_ready_i) begin
                  if (exp_q[0].l) done_next = 1;
                  void'(exp_q.pop_front());
                  hs_cnt++;
               end
            end
         end
      end
   end

   // Drives the link until the expected packet has drained; mode 0 ready, 1 = 1-on/2-off, 2 random.
   task automatic run_dump(input int mode, input bit inj);
      int t = 0;
      bit injd = 0;
      do begin
         cycle(-1);
         dump_req_i = 1'b0;
         snap_req_i = 1'b0;
         t++;
         case (mode)
            0: tx_ready_i = 1'b1;
            1: tx_ready_i = (t % 3 == 0);
            default: tx_ready_i = 1'($urandom_range(0, 1));
         endcase
         if (inj && !injd && hs_cnt >= 3) begin
            chk("busy_mid", 32'(busy_o), 32'h1);
            rand_live(0);
            apply_live();
            snap_req_i = 1'b1;
            dump_req_i = 1'b1;
            injd = 1;
         end
      end while ((exp_q.size() != 0 || busy_o) && t < 500);
      chk("dump_drained", exp_q.size(), 32'h0);
      repeat (4) cycle(-1);
      chk("busy_end", 32'(busy_o), 32'h0);
      chk("snap_valid", 32'(snap_valid_o), 32'(m_valid));
   endtask

   task automatic start_dump(input bit also_snap);
      cycle(-1);
      apply_live();
      dump_req_i = 1'b1;
      snap_req_i = also_snap;
      take_snap();
      push_packet();
   endtask

   initial begin
      int t;
      rst_i = 1'b1; snap_req_i = 0; dump_req_i = 0; tx_ready_i = 1'b1;
      rd_addr_i = '0; cnt_flat_i = '0; cyc_i = '0;
      for (int k = 0; k < NC; k++) m_cnt[k] = 32'h0;
      m_cyc = 64'h0; m_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_data", rd_data_o, 32'h0);
      chk("rst_tx_data", tx_data_o, 32'h0);
      chk("rst_flags", {27'h0, snap_valid_o, busy_o, tx_valid_o, tx_last_o, dump_done_o}, 32'h0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_flags_post", {27'h0, snap_valid_o, busy_o, tx_valid_o, tx_last_o, dump_done_o}, 32'h0);
      mon_en = 1; rd_en = 1;

      // Known counters k+1 with ready held high.
      for (int k = 0; k < NC; k++) live_cnt[k] = k + 1;
      live_cyc = 64'h1_0000_0005;
      start_dump(0);
      run_dump(0, 0);

      // Backpressure: ready 1 cycle on, 2 off.
      rand_live(0);
      start_dump(0);
      run_dump(1, 0);

      // Coherent snapshot, then live values change underneath it.
      rand_live(0);
      cycle(-1);
      apply_live();
      snap_req_i = 1'b1;
      take_snap();
      cycle(-1);
      snap_req_i = 1'b0;
      rand_live(0);
      apply_live();
      cycle(1);
      cycle(200);
      cycle(NC + 3);
      repeat (20) cycle(-1);
      chk("snap_valid", 32'(snap_valid_o), 32'h1);
      chk("snap_busy", 32'(busy_o), 32'h0);

      // Requests mid-packet must be ignored; random backpressure.
      rand_live(0);
      start_dump(0);
      run_dump(2, 1);

      // Snap and dump together, saturated counter values.
      rand_live(1);
      start_dump(1);
      run_dump(0, 0);

      // Asynchronous reset after word 4 has been accepted.
      rand_live(0);
      start_dump(0);
      t = 0;
      do begin
         cycle(-1);
         dump_req_i = 1'b0;
         tx_ready_i = 1'b1;
         t++;
      end while (hs_cnt < 5 && t < 100);
      chk("rst_hs_cnt", hs_cnt, 32'd5);
      mon_en = 0; rd_en = 0;
      rd_q.delete();
      exp_q.delete();
      #1 rst_i = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(tx_valid_o), 32'h0);
      chk("rst_mid_busy", 32'(busy_o), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      for (int k = 0; k < NC; k++) m_cnt[k] = 32'h0;
      m_cyc = 64'h0; m_valid = 0;
      chk("rst_mid_rd", rd_data_o, 32'h0);
      chk("rst_mid_snap", 32'(snap_valid_o), 32'h0);
      done_next = 0; mon_en = 1; rd_en = 1;
      repeat (8) cycle(-1);

      // Fresh dump after the abandoned one.
      rand_live(0);
      start_dump(0);
      run_dump(2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
